// File: rtl/ex_div_ctrl.sv
// EX-stage divide sequencer: radix-2 shift-subtract for div.w/mod.w/div.wu/mod.wu.
// 32 CALC cycles (zero divisor may short-cut to DONE); result held in DONE until ack.
module ex_div_ctrl #(
  parameter int XLEN      = 32,
  parameter bit ZERO_FAST = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            ack,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            mod_q, mod_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            s1_neg, s2_neg, src2_zero;
  logic [XLEN-1:0] mag1, mag2;
  logic [XLEN:0]   sh, trial;
  logic            tneg;
  logic [XLEN-1:0] rem_nx, quo_nx, q_fix, r_fix;

  assign s1_neg    = ~op[1] & src1[XLEN-1];
  assign s2_neg    = ~op[1] & src2[XLEN-1];
  assign src2_zero = (src2 == '0);
  assign mag1      = s1_neg ? -src1 : src1;
  assign mag2      = s2_neg ? -src2 : src2;

  // Remainder stays below the divisor, so a 33-bit trial never overflows.
  assign sh     = {rem_q, quo_q[XLEN-1]};
  assign trial  = sh - {1'b0, dvs_q};
  assign tneg   = trial[XLEN];
  assign rem_nx = tneg ? sh[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_nx = {quo_q[XLEN-2:0], ~tneg};
  assign q_fix  = qneg_q ? -quo_nx : quo_nx;
  assign r_fix  = rneg_q ? -rem_nx : rem_nx;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    mod_d    = mod_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (req && !flush) begin
          mod_d  = op[0];
          rem_d  = '0;
          quo_d  = mag1;
          dvs_d  = mag2;
          // A zero divisor yields all-ones quotient regardless of sign.
          qneg_d = (s1_neg ^ s2_neg) & ~src2_zero;
          rneg_d = s1_neg;
          cnt_d  = '1;
          if (ZERO_FAST && src2_zero) begin
            state_d  = S_DONE;
            result_d = op[0] ? src1 : '1;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          result_d = mod_q ? r_fix : q_fix;
        end
      end
      S_DONE: begin
        if (ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      mod_q    <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      mod_q    <= mod_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Directed + random bench for ex_div_ctrl; two instances (zero short-cut on/off) share stimulus.
module tb_ex_div_ctrl;

  localparam logic [1:0] DIV = 2'd0, MOD = 2'd1, DIVU = 2'd2, MODU = 2'd3;

  logic        clk = 1'b0;
  logic        reset, req, ack, flush;
  logic [1:0]  op;
  logic [31:0] src1, src2;
  logic        busy1, done1, busy0, done0;
  logic [31:0] result1, result0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_div_ctrl #(.XLEN(32), .ZERO_FAST(1'b1)) dut1 (
    .clk(clk), .reset(reset), .req(req), .op(op), .src1(src1), .src2(src2),
    .ack(ack), .flush(flush), .busy(busy1), .done(done1), .result(result1)
  );

  ex_div_ctrl #(.XLEN(32), .ZERO_FAST(1'b0)) dut0 (
    .clk(clk), .reset(reset), .req(req), .op(op), .src1(src1), .src2(src2),
    .ack(ack), .flush(flush), .busy(busy0), .done(done0), .result(result0)
  );

  // Reference: plain integer division on 64-bit values, zero-divisor rule applied first.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (b == 32'd0) return o[0] ? a : 32'hFFFF_FFFF;
    if (!o[1]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return o[0] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return o[0] ? (a % b) : (a / b);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives a request in the current cycle, waits for done on both DUTs, holds, then acks.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int hold);
    int cyc, lat1, lat0;
    req = 1'b1; op = o; src1 = a; src2 = b;
    @(negedge clk);
    cyc = 1; lat1 = -1; lat0 = -1;
    while ((lat1 < 0 || lat0 < 0) && cyc < 60) begin
      if (done1 && lat1 < 0) lat1 = cyc;
      if (done0 && lat0 < 0) lat0 = cyc;
      if (lat1 < 0 || lat0 < 0) begin
        req = 1'($urandom_range(0, 1)); op = 2'($urandom);
        src1 = $urandom; src2 = $urandom;
        @(negedge clk);
        cyc++;
      end
    end
    req = 1'b0;
    chk({tag, ".lat_fast"}, 32'(lat1), (b == 32'd0) ? 32'd1 : 32'd33);
    chk({tag, ".lat_full"}, 32'(lat0), 32'd33);
    chk({tag, ".res_fast"}, result1, exp);
    chk({tag, ".res_full"}, result0, exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, ".hold"}, {done1, done0, result1 ^ result0}, {2'b11, 32'd0});
      chk({tag, ".hold_res"}, result1, exp);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk({tag, ".idle"}, {busy1, done1, busy0, done0}, 32'd0);
  endtask

  initial begin
    int seen_done;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    reset = 1'b1; req = 1'b0; ack = 1'b0; flush = 1'b0;
    op = DIV; src1 = '0; src2 = '0;
    repeat (3) @(negedge clk);
    chk("reset.flags", {busy1, done1, busy0, done0}, 32'd0);
    chk("reset.res", result1 | result0, 32'd0);
    reset = 1'b0;

    run_op("div_100_7",  DIV,  32'd100,      32'd7,        32'd14,       0);
    run_op("mod_m7_2",   MOD,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0);
    run_op("div_m7_2",   DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0);
    run_op("divu_max_2", DIVU, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 0);
    run_op("div_ovf",    DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
    run_op("mod_ovf",    MOD,  32'h80000000, 32'hFFFFFFFF, 32'd0,        0);
    run_op("div_zero",   DIV,  32'd123,      32'd0,        32'hFFFFFFFF, 0);
    run_op("modu_zero",  MODU, 32'd123,      32'd0,        32'd123,      0);
    run_op("mod_neg_z",  MOD,  32'hFFFFFF85, 32'd0,        32'hFFFFFF85, 0);
    run_op("divm_zero",  DIV,  32'hFFFFFF85, 32'd0,        32'hFFFFFFFF, 0);
    run_op("bp_hold",    DIVU, 32'd1000,     32'd9,        32'd111,      5);
    run_op("after_ack",  MODU, 32'd1000,     32'd9,        32'd1,        0);

    // Flush in CALC cycle 10, with a competing request in the same cycle.
    req = 1'b1; op = DIV; src1 = 32'd100; src2 = 32'd7;
    @(negedge clk);
    req = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1; req = 1'b1; src1 = 32'd9; src2 = 32'd3;
    @(negedge clk);
    flush = 1'b0; req = 1'b0;
    chk("flush.flags", {busy1, done1, busy0, done0}, 32'd0);
    seen_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done1 || done0 || busy1 || busy0) seen_done++;
    end
    chk("flush.quiet", 32'(seen_done), 32'd0);
    run_op("post_flush", DIV, 32'd50, 32'd5, 32'd10, 0);

    for (int i = 0; i < 20; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 20);
        2:       rb = 32'hFFFFFFFF - $urandom_range(0, 20);
        default: rb = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), ro, ra, rb, model(ro, ra, rb), $urandom_range(0, 3));
    end

    // Reset mid-CALC clears everything, result included.
    req = 1'b1; op = DIVU; src1 = 32'd1000; src2 = 32'd3;
    @(negedge clk);
    req = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid.flags", {busy1, done1, busy0, done0}, 32'd0);
    chk("rst_mid.res", result1 | result0, 32'd0);
    run_op("post_reset", MOD, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
